multdiv_ctrl: RTL and testbench

Multicycle multiply/divide sequencer attached beside the single-cycle processor datapath. It accepts a signed 32-bit mul or div request decoded from an R-type instruction, holds the processor via a stall line while an iterative shift-add/restoring-subtract engine runs, then presents one result cycle. That cycle carries the value, the destination register and any exception status for the processor's writeback mux. Only one operation is in flight at a time.

---
 rtl/multdiv_ctrl.sv | 112 +++++++++++
 tb/tb_multdiv_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: iterative signed 32-bit multiply/divide sequencer that stalls the core and presents a one-cycle result.
module multdiv_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       dest_reg,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_reg,
  output logic             exception,
  output logic [WIDTH-1:0] exc_code
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [WIDTH-1:0] MUL_CODE = WIDTH'(MUL_EXC_CODE);
  localparam logic [WIDTH-1:0] DIV_CODE = WIDTH'(DIV_EXC_CODE);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               neg_q, neg_d, mul_q, mul_d, exc_q, exc_d;
  logic [4:0]         rd_q, rd_d;
  logic               a_neg, b_neg, div_zero, div_ovf, div_ge, mul_ovf, done;
  logic [WIDTH-1:0]   a_mag, b_mag, div_diff, quot;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod;
  // acc holds {partial product hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    a_neg    = operandA[WIDTH-1];
    b_neg    = operandB[WIDTH-1];
    a_mag    = a_neg ? -operandA : operandA;
    b_mag    = b_neg ? -operandB : operandB;
    div_zero = operandB == '0;
    div_ovf  = operandA == MIN_NEG && &operandB;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_sh >= {1'b0, opd_q};
    div_diff = div_sh[WIDTH-1:0] - opd_q;
    prod     = neg_q ? -acc_q : acc_q;
    quot     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    mul_ovf  = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    mul_d    = mul_q;
    exc_d    = exc_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: if (start_mult | start_div) begin
        acc_d   = {{WIDTH{1'b0}}, start_mult ? b_mag : (div_zero ? '0 : a_mag)};
        opd_d   = start_mult ? a_mag : b_mag;
        neg_d   = a_neg ^ b_neg;
        mul_d   = start_mult;
        exc_d   = !start_mult && (div_zero || div_ovf);
        rd_d    = dest_reg;
        cnt_d   = '0;
        state_d = start_mult ? MUL : (div_zero ? DONE : DIV);
      end
      MUL: begin
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'(WIDTH-1) ? DONE : MUL;
      end
      DIV: begin
        acc_d   = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'(WIDTH-1) ? DONE : DIV;
      end
      default: state_d = IDLE;
    endcase
    done         = state_q == DONE;
    busy         = state_q != IDLE;
    stall        = (state_q == IDLE && (start_mult || start_div)) || state_q == MUL || state_q == DIV;
    result_valid = done;
    result       = done ? (mul_q ? prod[WIDTH-1:0] : quot) : '0;
    result_reg   = done ? rd_q : '0;
    exception    = done && (mul_q ? mul_ovf : exc_q);
    exc_code     = exception ? (mul_q ? MUL_CODE : DIV_CODE) : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      neg_q   <= 1'b0;
      mul_q   <= 1'b0;
      exc_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      neg_q   <= neg_d;
      mul_q   <= mul_d;
      exc_q   <= exc_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: table-driven vectors with a result scoreboard plus reset and ignored-start sequences.
module tb_multdiv_ctrl;
  logic        clock = 1'b0, reset = 1'b1, start_mult = 1'b0, start_div = 1'b0;
  logic [31:0] operandA = '0, operandB = '0;
  logic [4:0]  dest_reg = '0;
  logic        stall, busy, result_valid, exception;
  logic [31:0] result, exc_code;
  logic [4:0]  result_reg;
  typedef struct {
    logic m, d;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] res;
    logic exc;
    logic [31:0] code;
    int lat, pulse;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic [4:0] rd;
    logic exc;
    logic [31:0] code;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[13];
  int n_cmp = 0, n_err = 0, n_valid = 0;
  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .operandA(operandA), .operandB(operandB), .dest_reg(dest_reg),
    .stall(stall), .busy(busy), .result_valid(result_valid), .result(result),
    .result_reg(result_reg), .exception(exception), .exc_code(exc_code)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clock) if (result_valid) begin
    exp_t e;
    n_valid++;
    if (sb.size() == 0) chk("spurious_valid", 64'(result_valid), 64'd0);
    else begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("result_reg", result_reg, e.rd);
      chk("exception", exception, e.exc);
      chk("exc_code", exc_code, e.code);
      chk("stall_in_done", stall, 0);
    end
  end
  // called at a negedge; drives the request so it is accepted at the next rising edge
  task automatic run_op(input vec_t v);
    exp_t e;
    int lat, nv0;
    logic ok;
    start_mult = v.m; start_div = v.d; operandA = v.a; operandB = v.b; dest_reg = v.rd;
    e.res = v.res; e.rd = v.rd; e.exc = v.exc; e.code = v.code;
    sb.push_back(e);
    #1;
    chk("stall_at_request", stall, 1);
    chk("busy_at_request", busy, 0);
    lat = 0; ok = 1'b1; nv0 = n_valid;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clock);
      start_mult = 1'b0;
      start_div = (i == v.pulse);
      if (result_valid) lat = i;
      else if (!stall || !busy) ok = 1'b0;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    chk("stall_busy_during_op", ok, 1);
    @(negedge clock);
    start_div = 1'b0;
    chk("idle_after_done", {busy, result_valid}, 0);
    chk("single_valid", 64'(n_valid - nv0), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t v;
    int nv0;
    tbl[0]  = '{1, 0, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0, 32'd0, 33, 0};
    tbl[1]  = '{1, 0, 32'h00010000,  32'h00010000, 5'd1,  32'h00000000, 1, 32'd4, 33, 0};
    tbl[2]  = '{0, 1, 32'hFFFFFFF9,  32'd2,        5'd9,  32'hFFFFFFFD, 0, 32'd0, 33, 0};
    tbl[3]  = '{0, 1, 32'h80000000,  32'hFFFFFFFF, 5'd3,  32'h80000000, 1, 32'd5, 33, 0};
    tbl[4]  = '{0, 1, 32'd5,         32'd0,        5'd7,  32'h00000000, 1, 32'd5, 1,  0};
    tbl[5]  = '{1, 1, 32'd6,         32'd3,        5'd2,  32'd18,       0, 32'd0, 33, 10};
    tbl[6]  = '{1, 0, 32'hFFFFFFFB,  32'hFFFFFFFA, 5'd4,  32'd30,       0, 32'd0, 33, 0};
    tbl[7]  = '{0, 1, 32'd100,       32'hFFFFFFF9, 5'd6,  32'hFFFFFFF2, 0, 32'd0, 33, 0};
    tbl[8]  = '{1, 0, 32'h80000000,  32'd1,        5'd8,  32'h80000000, 0, 32'd0, 33, 0};
    tbl[9]  = '{1, 0, 32'h80000000,  32'hFFFFFFFF, 5'd10, 32'h80000000, 1, 32'd4, 33, 0};
    tbl[10] = '{0, 1, 32'hFFFFFFFF,  32'h80000000, 5'd11, 32'h00000000, 0, 32'd0, 33, 0};
    tbl[11] = '{0, 1, 32'h7FFFFFFF,  32'd1,        5'd31, 32'h7FFFFFFF, 0, 32'd0, 33, 0};
    tbl[12] = '{1, 0, 32'h0000FFFF,  32'h0000FFFF, 5'd12, 32'hFFFE0001, 1, 32'd4, 33, 0};
    repeat (3) @(negedge clock);
    chk("reset_outputs", {stall, busy, result_valid, result, result_reg, exception, exc_code}, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_outputs", {stall, busy, result_valid, result, exc_code}, 0);
    for (int k = 0; k < 13; k++) run_op(tbl[k]);
    start_mult = 1'b1; operandA = 32'd2; operandB = 32'd3; dest_reg = 5'd13;
    nv0 = n_valid;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      start_mult = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset_mid_op_busy_stall", {busy, stall, result_valid}, 0);
    repeat (40) @(negedge clock);
    chk("no_valid_after_reset", 64'(n_valid - nv0), 0);
    v = '{1, 0, 32'd2, 32'd3, 5'd14, 32'd6, 0, 32'd0, 33, 0};
    run_op(v);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
